// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-access stage. pipes holds the stage-local types;
// common holds the data-bus request/response records.
package pipes;
  typedef enum logic [1:0] {MSZ_B = 2'd0, MSZ_H = 2'd1, MSZ_W = 2'd2, MSZ_D = 2'd3} msize_t;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD, S_DRAIN} mem_state_t;

  function automatic logic is_aligned(input logic [2:0] off, input msize_t sz);
    unique case (sz)
      MSZ_B:   is_aligned = 1'b1;
      MSZ_H:   is_aligned = (off[0] == 1'b0);
      MSZ_W:   is_aligned = (off[1:0] == 2'b00);
      default: is_aligned = (off == 3'b000);
    endcase
  endfunction
endpackage

package common;
  typedef struct packed {
    logic          valid;
    logic [63:0]   addr;
    pipes::msize_t size;
    logic [7:0]    strobe;
    logic [63:0]   data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering for the data bus: store strobe/data placement and
// load data extraction with zero/sign extension.
module mem_lane_align
  import pipes::*;
(
  input  logic [2:0]  off_i,
  input  msize_t      size_i,
  input  logic        write_i,
  input  logic        unsigned_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rraw_i,
  output logic [7:0]  strobe_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);
  logic [5:0]  sh;
  logic [63:0] rsh;
  logic [7:0]  base;

  assign sh  = {off_i, 3'b000};
  assign rsh = rraw_i >> sh;

  always_comb begin
    base = 8'h01;
    unique case (size_i)
      MSZ_B:   base = 8'h01;
      MSZ_H:   base = 8'h03;
      MSZ_W:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
  end

  // Narrow strobes shift with the offset and fall off the top of the 8-bit lane.
  assign strobe_o = !write_i        ? 8'h00 :
                    (size_i == MSZ_D) ? 8'hFF : (base << off_i);
  assign wdata_o  = write_i ? (wdata_i << sh) : 64'd0;

  always_comb begin
    rdata_o = rraw_i;
    unique case (size_i)
      MSZ_B:   rdata_o = unsigned_i ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
      MSZ_H:   rdata_o = unsigned_i ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      MSZ_W:   rdata_o = unsigned_i ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      default: rdata_o = rraw_i;
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus controller: one outstanding access, flush/drain handling.
// Optional MEM_MISALIGN_CHECK_EN traps unaligned accesses without a bus cycle.
module mem_access_ctrl
  import pipes::*, common::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  msize_t      req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  input  logic        flush,
  input  logic        advance,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        misalign
);
  mem_state_t  state_q, state_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  msize_t      size_q, size_d;
  logic        write_q, write_d, uns_q, uns_d, mis_q, mis_d;
  logic        bus_vld, misaligned_in;
  logic [7:0]  strobe;
  logic [63:0] bus_data, ext_data;
  logic        unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned_in = !is_aligned(req_addr[2:0], req_size);
`else
  assign misaligned_in = 1'b0;
`endif

  mem_lane_align u_align (
    .off_i      (addr_q[2:0]),
    .size_i     (size_q),
    .write_i    (write_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rraw_i     (dresp.data),
    .strobe_o   (strobe),
    .wdata_o    (bus_data),
    .rdata_o    (ext_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    stall   = 1'b0;
    done    = 1'b0;
    bus_vld = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          stall   = 1'b1;
          addr_d  = req_addr;
          size_d  = req_size;
          write_d = req_write;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = 64'd0;
          mis_d   = misaligned_in;
          state_d = misaligned_in ? S_HOLD : S_BUSY;
        end
      end
      S_BUSY: begin
        stall   = 1'b1;
        bus_vld = 1'b1;
        if (dresp.data_ok) begin
          if (flush) state_d = S_IDLE;
          else begin
            state_d = S_HOLD;
            rdata_d = write_q ? 64'd0 : ext_data;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      // Killed access: keep the bus request up until the slave answers.
      S_DRAIN: begin
        stall   = 1'b1;
        bus_vld = 1'b1;
        if (dresp.data_ok) state_d = S_IDLE;
      end
      S_HOLD: begin
        done = !flush;
        if (flush || advance) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 64'd0;
      size_q  <= MSZ_B;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Reset drops the bus request in the same cycle it is asserted.
  assign dreq.valid  = bus_vld & ~reset;
  assign dreq.addr   = addr_q;
  assign dreq.size   = size_q;
  assign dreq.strobe = strobe;
  assign dreq.data   = bus_data;
  assign rdata       = rdata_q;
  assign misalign    = mis_q & done;
endmodule
